// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter between the RX-echo and push-button requesters
module uart_tx_scheduler #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int START_TIMEOUT   = 16
) (
  input  logic       src_clk_i,
  input  logic       rst_i,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  input  logic       echo_en_i,
  input  logic       src_sel_i,
  input  logic [6:0] sw_data_i,
  input  logic       send_btn_n_i,
  input  logic       tx_busy_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  output logic [1:0] pending_o,
  output logic [7:0] drop_count_o
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic btn_s1_q, btn_s2_q, deb_q, deb_prev_q, deb_hit, press;
  logic [DW-1:0] deb_cnt_q;
  logic [TW-1:0] tmr_q;
  logic [7:0] last_rx_q, echo_q, btn_q, tx_data_q, drop_q, drop_d;
  logic echo_v_q, btn_v_q, last_btn_q;
  logic issue, grant_echo, grant_btn, echo_req, echo_drop, btn_drop;
  logic [8:0] drop_sum;
  assign deb_hit    = (btn_s2_q != deb_q) && (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1));
  assign press      = deb_prev_q & ~deb_q;
  assign echo_req   = rx_valid_i & echo_en_i;
  assign issue      = (state_q == IDLE) && (echo_v_q || btn_v_q) && !tx_busy_i;
  assign grant_echo = issue && echo_v_q && (!btn_v_q || last_btn_q);
  assign grant_btn  = issue && !grant_echo;
  assign echo_drop  = echo_req & echo_v_q & ~grant_echo;
  assign btn_drop   = press & btn_v_q & ~grant_btn;
  assign drop_sum   = {1'b0, drop_q} + 9'(echo_drop) + 9'(btn_drop);
  assign drop_d     = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  assign tx_data_o    = tx_data_q;
  assign pending_o    = {btn_v_q, echo_v_q};
  assign drop_count_o = drop_q;
  // FSM state register
  always_ff @(posedge src_clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  end
  // FSM next state: one grant at a time, abandon a frame whose start never shows up as busy
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = issue ? ISSUE : IDLE;
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: state_d = tx_busy_i ? WAIT_DONE : (tmr_q == TW'(START_TIMEOUT - 1)) ? IDLE : WAIT_BUSY;
      default:   state_d = tx_busy_i ? WAIT_DONE : IDLE;
    endcase
  end
  // FSM outputs: start pulse lives only in ISSUE
  always_comb begin
    tx_start_o = (state_q == ISSUE);
  end
  // Button synchronizer, debounce and press-edge detection
  always_ff @(posedge src_clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_s1_q   <= 1'b1;
      btn_s2_q   <= 1'b1;
      deb_q      <= 1'b1;
      deb_prev_q <= 1'b1;
      deb_cnt_q  <= '0;
    end else begin
      btn_s1_q   <= send_btn_n_i;
      btn_s2_q   <= btn_s1_q;
      deb_q      <= deb_hit ? btn_s2_q : deb_q;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= (btn_s2_q == deb_q || deb_hit) ? '0 : deb_cnt_q + 1'b1;
    end
  end
  // Request slots, grant bookkeeping, start timeout and drop counter; a refill beats a same-cycle clear
  always_ff @(posedge src_clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_rx_q  <= '0;
      echo_q     <= '0;
      btn_q      <= '0;
      echo_v_q   <= 1'b0;
      btn_v_q    <= 1'b0;
      last_btn_q <= 1'b1;
      tx_data_q  <= '0;
      tmr_q      <= '0;
      drop_q     <= '0;
    end else begin
      if (rx_valid_i) last_rx_q <= rx_data_i;
      echo_v_q <= echo_req | (echo_v_q & ~grant_echo);
      if (echo_req && (!echo_v_q || grant_echo)) echo_q <= rx_data_i;
      btn_v_q <= press | (btn_v_q & ~grant_btn);
      if (press && (!btn_v_q || grant_btn)) btn_q <= src_sel_i ? {1'b0, sw_data_i} : last_rx_q;
      if (issue) begin
        tx_data_q  <= grant_echo ? echo_q : btn_q;
        last_btn_q <= grant_btn;
      end
      tmr_q  <= (state_q == WAIT_BUSY) ? tmr_q + 1'b1 : '0;
      drop_q <= drop_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: randomized self-checking bench with a transaction-level scheduler model
module tb_uart_tx_scheduler;
  localparam int D = 4;
  localparam int T = 16;
  logic clk = 0, rst = 1, rx_valid = 0, echo_en = 0, src_sel = 0, btn_n = 1;
  logic [7:0] rx_data = 0;
  logic [6:0] sw_data = 0;
  logic tx_busy, tx_start;
  logic [7:0] tx_data, drop_count;
  logic [1:0] pending;
  logic auto_mode = 0, man_busy = 0, fr_busy = 0;
  int fr_cnt = 0, frame_len = 6, cyc = 0;
  int compared = 0, mismatched = 0, exp_drop = 0;
  logic last_btn = 1;
  byte unsigned sent_d[$];
  int sent_t[$];

  uart_tx_scheduler #(.DEBOUNCE_CYCLES(D), .START_TIMEOUT(T)) dut (
    .src_clk_i(clk), .rst_i(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .echo_en_i(echo_en), .src_sel_i(src_sel), .sw_data_i(sw_data), .send_btn_n_i(btn_n),
    .tx_busy_i(tx_busy), .tx_start_o(tx_start), .tx_data_o(tx_data),
    .pending_o(pending), .drop_count_o(drop_count));

  assign tx_busy = auto_mode ? fr_busy : man_busy;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // transmitter stand-in and frame monitor
  always @(negedge clk) begin
    if (tx_start) begin
      sent_d.push_back(tx_data);
      sent_t.push_back(cyc);
    end
    if (tx_start && auto_mode) begin
      fr_busy = 1;
      fr_cnt = frame_len;
    end else if (fr_cnt > 0) begin
      fr_cnt--;
      if (fr_cnt == 0) fr_busy = 0;
    end
  end

  function automatic int sat(int v);
    return v > 255 ? 255 : v;
  endfunction

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(byte unsigned v);
    rx_data = v;
    rx_valid = 1;
    step();
    rx_valid = 0;
  endtask

  task automatic press(int hold);
    btn_n = 0;
    step(hold);
    btn_n = 1;
    step(D + 4);
  endtask

  task automatic wait_quiet(string nm);
    int q = 0;
    for (int i = 0; i < 400 && q < 4; i++) begin
      step();
      q = (pending == 0 && tx_busy == 0 && !tx_start) ? q + 1 : 0;
    end
    compared++;
    if (q < 4) begin
      mismatched++;
      $display("FAIL %s_idle_wait: pending=%b busy=%b, required idle within 400 cycles", nm, pending, tx_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    step(2);
    compared += 4;
    if (tx_start !== 1'b0) begin mismatched++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    if (tx_data !== 8'h00) begin mismatched++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    if (pending !== 2'b00) begin mismatched++; $display("FAIL reset_pending: got %b want 00", pending); end
    if (drop_count !== 8'h00) begin mismatched++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    rst = 0;
    step(3);
    compared++;
    if (tx_start !== 1'b0 || pending !== 2'b00) begin
      mismatched++;
      $display("FAIL reset_release_quiet: start=%b pending=%b want 0/00", tx_start, pending);
    end
  endtask

  task automatic test_echo();
    byte unsigned exp[$];
    byte unsigned b;
    int n0;
    echo_en = 1;
    auto_mode = 1;
    frame_len = 6;
    n0 = sent_d.size();
    send_rx(8'h52);
    compared += 2;
    if (pending !== 2'b01) begin mismatched++; $display("FAIL echo_slot_c1: pending=%b want 01", pending); end
    if (tx_start !== 1'b0) begin mismatched++; $display("FAIL echo_early_start: got %b want 0", tx_start); end
    step();
    compared += 3;
    if (tx_start !== 1'b1) begin mismatched++; $display("FAIL echo_start_c2: got %b want 1", tx_start); end
    if (tx_data !== 8'h52) begin mismatched++; $display("FAIL echo_data: got %h want 52", tx_data); end
    if (pending !== 2'b00) begin mismatched++; $display("FAIL echo_pending_clr: got %b want 00", pending); end
    step();
    compared++;
    if (tx_start !== 1'b0) begin mismatched++; $display("FAIL echo_pulse_width: got %b want 0", tx_start); end
    wait_quiet("echo");
    exp.push_back(8'h52);
    for (int k = 0; k < 8; k++) begin
      frame_len = $urandom_range(3, 12);
      b = 8'($urandom);
      exp.push_back(b);
      send_rx(b);
      if ($urandom_range(0, 2) == 0) begin
        b = 8'($urandom);
        exp.push_back(b);
        send_rx(b);
      end
      wait_quiet("echo_rand");
    end
    compared++;
    if (sent_d.size() - n0 !== exp.size()) begin
      mismatched++;
      $display("FAIL echo_frame_count: got %0d want %0d", sent_d.size() - n0, exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        compared++;
        if (sent_d[n0 + i] !== exp[i]) begin
          mismatched++;
          $display("FAIL echo_seq[%0d]: got %h want %h", i, sent_d[n0 + i], exp[i]);
        end
      end
    end
    compared++;
    if (drop_count !== 8'(exp_drop)) begin mismatched++; $display("FAIL echo_no_drop: got %0d want %0d", drop_count, exp_drop); end
    last_btn = 0;
  endtask

  task automatic test_btn_switch();
    int n0, t0;
    echo_en = 0;
    src_sel = 1;
    sw_data = 7'h5A;
    n0 = sent_d.size();
    t0 = cyc;
    press(10);
    wait_quiet("btn_sw");
    compared++;
    if (sent_d.size() !== n0 + 1) begin
      mismatched++;
      $display("FAIL btn_sw_count: got %0d frames want 1", sent_d.size() - n0);
    end else begin
      compared += 2;
      if (sent_d[n0] !== 8'h5A) begin mismatched++; $display("FAIL btn_sw_data: got %h want 5a", sent_d[n0]); end
      if (sent_t[n0] - t0 !== D + 4) begin mismatched++; $display("FAIL btn_sw_latency: got %0d want %0d", sent_t[n0] - t0, D + 4); end
    end
    n0 = sent_d.size();
    btn_n = 0;
    step(2);
    btn_n = 1;
    step(20);
    compared += 2;
    if (sent_d.size() !== n0) begin mismatched++; $display("FAIL btn_glitch_frames: got %0d want 0", sent_d.size() - n0); end
    if (pending !== 2'b00) begin mismatched++; $display("FAIL btn_glitch_pending: got %b want 00", pending); end
    last_btn = 1;
  endtask

  task automatic test_btn_last_rx();
    byte unsigned b;
    int n0;
    echo_en = 0;
    for (int k = 0; k < 3; k++) begin
      b = (k == 0) ? 8'h41 : 8'($urandom);
      send_rx(b);
      step(2);
      src_sel = 0;
      sw_data = 7'($urandom);
      n0 = sent_d.size();
      press(10);
      wait_quiet("btn_rx");
      compared++;
      if (sent_d.size() !== n0 + 1) begin
        mismatched++;
        $display("FAIL btn_rx_count[%0d]: got %0d frames want 1", k, sent_d.size() - n0);
      end else begin
        compared++;
        if (sent_d[n0] !== b) begin mismatched++; $display("FAIL btn_rx_data[%0d]: got %h want %h", k, sent_d[n0], b); end
      end
    end
    last_btn = 1;
  endtask

  task automatic test_round_robin();
    byte unsigned e, s, first, second;
    int n0;
    bit lone_echo;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        lone_echo = (k == 1) ? 1'b1 : (k == 2) ? 1'b0 : 1'($urandom);
        if (lone_echo) begin
          echo_en = 1;
          send_rx(8'($urandom));
          last_btn = 0;
        end else begin
          echo_en = 0;
          src_sel = 1;
          sw_data = 7'($urandom);
          press(10);
          last_btn = 1;
        end
        wait_quiet("rr_lone");
      end
      n0 = sent_d.size();
      auto_mode = 0;
      man_busy = 1;
      echo_en = 1;
      e = (k == 0) ? 8'h31 : 8'($urandom);
      send_rx(e);
      echo_en = 0;
      src_sel = 1;
      sw_data = (k == 0) ? 7'h5A : 7'($urandom);
      s = {1'b0, sw_data};
      press(10);
      compared += 2;
      if (pending !== 2'b11) begin mismatched++; $display("FAIL rr_both_pending[%0d]: got %b want 11", k, pending); end
      if (sent_d.size() !== n0) begin mismatched++; $display("FAIL rr_busy_hold[%0d]: got %0d frames want 0", k, sent_d.size() - n0); end
      auto_mode = 1;
      man_busy = 0;
      wait_quiet("rr");
      first = last_btn ? e : s;
      second = last_btn ? s : e;
      compared++;
      if (sent_d.size() !== n0 + 2) begin
        mismatched++;
        $display("FAIL rr_count[%0d]: got %0d frames want 2", k, sent_d.size() - n0);
      end else begin
        compared += 2;
        if (sent_d[n0] !== first) begin mismatched++; $display("FAIL rr_first[%0d]: got %h want %h", k, sent_d[n0], first); end
        if (sent_d[n0 + 1] !== second) begin mismatched++; $display("FAIL rr_second[%0d]: got %h want %h", k, sent_d[n0 + 1], second); end
      end
    end
  endtask

  task automatic test_overflow();
    byte unsigned f, s;
    int n0, n;
    auto_mode = 0;
    man_busy = 1;
    echo_en = 1;
    n0 = sent_d.size();
    send_rx(8'h01);
    send_rx(8'h02);
    send_rx(8'h03);
    step();
    exp_drop = sat(exp_drop + 2);
    compared += 2;
    if (pending !== 2'b01) begin mismatched++; $display("FAIL ovf_pending: got %b want 01", pending); end
    if (drop_count !== 8'(exp_drop)) begin mismatched++; $display("FAIL ovf_drop3: got %0d want %0d", drop_count, exp_drop); end
    auto_mode = 1;
    man_busy = 0;
    wait_quiet("ovf");
    compared++;
    if (sent_d.size() !== n0 + 1 || sent_d[sent_d.size() - 1] !== 8'h01) begin
      mismatched++;
      $display("FAIL ovf_kept_first: frames=%0d last=%h want 1 frame of 01", sent_d.size() - n0, sent_d[sent_d.size() - 1]);
    end
    last_btn = 0;
    auto_mode = 0;
    man_busy = 1;
    n0 = sent_d.size();
    n = $urandom_range(2, 6);
    f = 8'($urandom);
    send_rx(f);
    for (int i = 1; i < n; i++) send_rx(8'($urandom));
    exp_drop = sat(exp_drop + n - 1);
    src_sel = 1;
    sw_data = 7'($urandom);
    s = {1'b0, sw_data};
    press(10);
    sw_data = 7'($urandom);
    btn_n = 0;
    for (int i = 0; i < 12; i++) send_rx(8'($urandom));
    btn_n = 1;
    step(D + 4);
    exp_drop = sat(exp_drop + 13);
    compared++;
    if (drop_count !== 8'(exp_drop)) begin mismatched++; $display("FAIL ovf_dual_drop: got %0d want %0d", drop_count, exp_drop); end
    auto_mode = 1;
    man_busy = 0;
    wait_quiet("ovf_dual");
    compared++;
    if (sent_d.size() !== n0 + 2) begin
      mismatched++;
      $display("FAIL ovf_dual_count: got %0d frames want 2", sent_d.size() - n0);
    end else begin
      compared += 2;
      if (sent_d[n0] !== (last_btn ? f : s)) begin mismatched++; $display("FAIL ovf_dual_first: got %h want %h", sent_d[n0], last_btn ? f : s); end
      if (sent_d[n0 + 1] !== (last_btn ? s : f)) begin mismatched++; $display("FAIL ovf_dual_second: got %h want %h", sent_d[n0 + 1], last_btn ? s : f); end
    end
    auto_mode = 0;
    man_busy = 1;
    rx_data = 8'($urandom);
    rx_valid = 1;
    step(301);
    rx_valid = 0;
    exp_drop = sat(exp_drop + 300);
    compared++;
    if (drop_count !== 8'(exp_drop)) begin mismatched++; $display("FAIL ovf_saturate: got %0d want %0d", drop_count, exp_drop); end
    auto_mode = 1;
    man_busy = 0;
    wait_quiet("ovf_sat");
    compared++;
    if (drop_count !== 8'(exp_drop)) begin mismatched++; $display("FAIL ovf_sat_hold: got %0d want %0d", drop_count, exp_drop); end
    last_btn = 0;
  endtask

  task automatic test_timeout();
    byte unsigned a, b;
    int n0;
    auto_mode = 0;
    man_busy = 0;
    echo_en = 1;
    n0 = sent_d.size();
    a = 8'($urandom);
    b = 8'($urandom);
    send_rx(a);
    for (int i = 0; i < 10 && !tx_start; i++) step();
    compared++;
    if (tx_start !== 1'b1) begin mismatched++; $display("FAIL to_first_start: got %b want 1", tx_start); end
    send_rx(b);
    step(45);
    compared += 2;
    if (pending !== 2'b00) begin mismatched++; $display("FAIL to_pending: got %b want 00", pending); end
    if (sent_d.size() !== n0 + 2) begin
      mismatched++;
      $display("FAIL to_count: got %0d frames want 2", sent_d.size() - n0);
    end else begin
      compared += 3;
      if (sent_d[n0] !== a) begin mismatched++; $display("FAIL to_data_a: got %h want %h", sent_d[n0], a); end
      if (sent_d[n0 + 1] !== b) begin mismatched++; $display("FAIL to_data_b: got %h want %h", sent_d[n0 + 1], b); end
      if (sent_t[n0 + 1] - sent_t[n0] !== T + 2) begin
        mismatched++;
        $display("FAIL to_spacing: got %0d want %0d", sent_t[n0 + 1] - sent_t[n0], T + 2);
      end
    end
    last_btn = 0;
  endtask

  task automatic test_reset_mid_frame();
    byte unsigned z;
    int n0;
    auto_mode = 1;
    frame_len = 20;
    echo_en = 1;
    send_rx(8'($urandom));
    for (int i = 0; i < 10 && !tx_busy; i++) step();
    step();
    send_rx(8'($urandom));
    compared++;
    if (pending !== 2'b01) begin mismatched++; $display("FAIL rst_pre_pending: got %b want 01", pending); end
    #2;
    rst = 1;
    #1;
    exp_drop = 0;
    last_btn = 1;
    compared += 4;
    if (tx_start !== 1'b0) begin mismatched++; $display("FAIL rst_mid_start: got %b want 0", tx_start); end
    if (tx_data !== 8'h00) begin mismatched++; $display("FAIL rst_mid_data: got %h want 00", tx_data); end
    if (pending !== 2'b00) begin mismatched++; $display("FAIL rst_mid_pending: got %b want 00", pending); end
    if (drop_count !== 8'(exp_drop)) begin mismatched++; $display("FAIL rst_mid_drop: got %0d want 0", drop_count); end
    step();
    rst = 0;
    n0 = sent_d.size();
    step(40);
    compared++;
    if (sent_d.size() !== n0) begin mismatched++; $display("FAIL rst_no_frame: got %0d frames want 0", sent_d.size() - n0); end
    frame_len = 5;
    z = 8'($urandom);
    send_rx(z);
    wait_quiet("rst_after");
    compared++;
    if (sent_d.size() !== n0 + 1 || sent_d[sent_d.size() - 1] !== z) begin
      mismatched++;
      $display("FAIL rst_new_req: frames=%0d last=%h want 1 frame of %h", sent_d.size() - n0, sent_d[sent_d.size() - 1], z);
    end
  endtask

  initial begin
    test_reset();
    test_echo();
    test_btn_switch();
    test_btn_last_rx();
    test_round_robin();
    test_overflow();
    test_timeout();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
